text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer.sv | 177 +++++++++++++++++
 tb/tb_text_renderer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_renderer.sv
// Character-cell text renderer: prefetches one cell ahead from display and font memory
// and emits one registered 4-bit colour per pixel clock. Cursor/blink logic is built only with TXT_CURSOR_EN.
module text_renderer #(
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  pix_x,
    input  logic [9:0]                  pix_y,
    output logic [ADDR_W-1:0]           ascii_address,
    output logic                        disp_mem_en,
    input  logic [7:0]                  char_code,
    input  logic [7:0]                  attr,
    output logic [8+$clog2(CHAR_H)-1:0] font_address,
    output logic                        font_mem_en,
    input  logic [CHAR_W-1:0]           font_line_data,
    input  logic                        cursor_en,
    input  logic [7:0]                  cursor_x,
    input  logic [7:0]                  cursor_y,
    output logic [3:0]                  pix_color
);

    localparam int PW       = $clog2(CHAR_W);
    localparam int RW       = $clog2(CHAR_H);
    localparam int X_ACTIVE = COLS * CHAR_W;
    localparam int Y_ACTIVE = ROWS * CHAR_H;

    logic [ADDR_W-1:0] r_ascii_address;
    logic              r_disp_mem_en;
    logic [8+RW-1:0]   r_font_address;
    logic              r_font_mem_en;
    logic [CHAR_W-1:0] r_line_pend;
    logic [CHAR_W-1:0] r_shifter;
    logic [7:0]        r_attr_pend;
    logic [7:0]        r_attr_cur;
    logic [3:0]        r_pix_color;

    logic [PW-1:0]     w_p;
    int                w_fx;
    int                w_fy;
    int                w_addr;
    logic              w_fetch_valid;
    logic              w_swap;
    logic              w_pix_bit;
    logic [3:0]        w_fg;
    logic [3:0]        w_bg;
    logic [3:0]        w_color;

    assign w_p = pix_x[PW-1:0];

    // Fetch runs one cell ahead of the beam, wrapping onto the next line (and frame).
    always_comb begin
        w_fx = int'(pix_x) + CHAR_W;
        w_fy = int'(pix_y);
        if (w_fx >= H_TOTAL) begin
            w_fx = w_fx - H_TOTAL;
            w_fy = (w_fy + 1 >= V_TOTAL) ? 0 : w_fy + 1;
        end
        w_fetch_valid = (w_fx < X_ACTIVE) && (w_fy < Y_ACTIVE);
        w_addr        = (w_fy / CHAR_H) * COLS + (w_fx / CHAR_W);
    end

    always_comb begin
        w_pix_bit = r_shifter[PW'(CHAR_W-1) - w_p];
        w_fg      = r_attr_cur[3:0];
        w_bg      = r_attr_cur[7:4];
        if (w_swap) begin
            w_fg = r_attr_cur[7:4];
            w_bg = r_attr_cur[3:0];
        end
        w_color = w_pix_bit ? w_fg : w_bg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ascii_address <= '0;
            r_disp_mem_en   <= 1'b0;
            r_font_address  <= '0;
            r_font_mem_en   <= 1'b0;
            r_line_pend     <= '0;
            r_shifter       <= '0;
            r_attr_pend     <= '0;
            r_attr_cur      <= '0;
            r_pix_color     <= '0;
        end else begin
            r_disp_mem_en <= 1'b0;
            r_font_mem_en <= 1'b0;
            if (w_p == '0 && w_fetch_valid) begin
                r_ascii_address <= ADDR_W'(w_addr);
                r_disp_mem_en   <= 1'b1;
            end
            if (w_p == PW'(1)) begin
                if (w_fetch_valid) begin
                    r_font_address <= {char_code, w_fy[RW-1:0]};
                    r_font_mem_en  <= 1'b1;
                    r_attr_pend    <= attr;
                end else begin
                    r_attr_pend    <= '0;
                end
            end
            if (w_p == PW'(2)) begin
                r_line_pend <= w_fetch_valid ? font_line_data : '0;
            end
            // Load on the last pixel of a cell so the new cell shows from its first pixel.
            if (w_p == PW'(CHAR_W-1)) begin
                r_shifter  <= r_line_pend;
                r_attr_cur <= r_attr_pend;
            end
            r_pix_color <= w_color;
        end
    end

`ifdef TXT_CURSOR_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    logic          r_inv;
    int            w_dx;
    int            w_dy;
    logic          w_cursor_hit;

    // Coordinates of the cell about to be loaded: the one starting at the next pixel.
    always_comb begin
        w_dx = int'(pix_x) + 1;
        w_dy = int'(pix_y);
        if (w_dx >= H_TOTAL) begin
            w_dx = 0;
            w_dy = (w_dy + 1 >= V_TOTAL) ? 0 : w_dy + 1;
        end
        w_cursor_hit = cursor_en && r_blink
                    && (w_dx / CHAR_W == int'(cursor_x))
                    && (w_dy / CHAR_H == int'(cursor_y))
                    && (w_dy % CHAR_H >= CHAR_H - 2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            if (pix_x == 10'd0 && pix_y == 10'd0) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES-1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
            if (w_p == PW'(CHAR_W-1)) begin
                r_inv <= w_cursor_hit;
            end
        end
    end

    assign w_swap = r_inv;
`else
    logic w_cursor_unused;
    assign w_cursor_unused = ^{cursor_en, cursor_x, cursor_y};
    assign w_swap          = 1'b0;
`endif

    assign ascii_address = r_ascii_address;
    assign disp_mem_en   = r_disp_mem_en;
    assign font_address  = r_font_address;
    assign font_mem_en   = r_font_mem_en;
    assign pix_color     = r_pix_color;

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: fetch-vector table, directed raster sequences and
// randomized scans against a pixel-level model of the character display.
module tb_text_renderer;

  localparam int CW   = 8;
  localparam int CH   = 16;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int HT   = 800;
  localparam int VT   = 525;
  localparam int AW   = 12;
  localparam int BF   = 16;

  logic          clk;
  logic          reset;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic [AW-1:0] ascii_address;
  logic          disp_mem_en;
  logic [7:0]    char_code;
  logic [7:0]    attr;
  logic [11:0]   font_address;
  logic          font_mem_en;
  logic [CW-1:0] font_line_data;
  logic          cursor_en;
  logic [7:0]    cursor_x;
  logic [7:0]    cursor_y;
  logic [3:0]    pix_color;

  text_renderer #(
    .CHAR_W(CW), .CHAR_H(CH), .COLS(COLS), .ROWS(ROWS),
    .H_TOTAL(HT), .V_TOTAL(VT), .ADDR_W(AW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ascii_address(ascii_address), .disp_mem_en(disp_mem_en),
    .char_code(char_code), .attr(attr),
    .font_address(font_address), .font_mem_en(font_mem_en),
    .font_line_data(font_line_data),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .pix_color(pix_color)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memories: data valid in the cycle after the registered request
  logic [7:0] mem_char[4096];
  logic [7:0] mem_attr[4096];
  logic [7:0] mem_font[4096];

  assign char_code      = disp_mem_en ? mem_char[ascii_address] : 8'h00;
  assign attr           = disp_mem_en ? mem_attr[ascii_address] : 8'h00;
  assign font_line_data = font_mem_en ? mem_font[font_address] : 8'h00;

  int n_pass;
  int n_total;
  int m_frames;

  typedef struct {
    int x;
    int y;
    bit en;
    int addr;
    int frow;
  } fetch_vec_t;

  fetch_vec_t vecs[10];

  // scoreboard helpers
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit fetch_valid(input int x, input int y);
    int fx;
    int fy;
    fx = x + CW;
    fy = y;
    if (fx >= HT) begin
      fx = fx - HT;
      fy = (y + 1) % VT;
    end
    return (fx < COLS * CW) && (fy < ROWS * CH);
  endfunction

  function automatic int model_pix(input int x, input int y);
    int idx;
    logic [7:0] code;
    logic [7:0] at;
    logic [7:0] line;
    int fg;
    int bg;
`ifdef TXT_CURSOR_EN
    int t;
`endif
    if (x >= COLS * CW || y >= ROWS * CH) return 0;
    idx  = (y / CH) * COLS + x / CW;
    code = mem_char[idx];
    at   = mem_attr[idx];
    line = mem_font[int'(code) * CH + y % CH];
    fg   = int'(at[3:0]);
    bg   = int'(at[7:4]);
`ifdef TXT_CURSOR_EN
    if (cursor_en && ((m_frames / BF) % 2 == 1) && (x / CW == int'(cursor_x)) &&
        (y / CH == int'(cursor_y)) && (y % CH >= CH - 2)) begin
      t  = fg;
      fg = bg;
      bg = t;
    end
`endif
    return line[CW - 1 - x % CW] ? fg : bg;
  endfunction

  // driver tasks
  task automatic step(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    if (x == 0 && y == 0 && !reset) m_frames++;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int x0, input int y0, input int n, input int skip);
    int x;
    int y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      step(x, y);
      if (i >= skip) check($sformatf("pix(%0d,%0d)", x, y), int'(pix_color), model_pix(x, y));
      check($sformatf("disp_en(%0d,%0d)", x, y), int'(disp_mem_en),
            (x % CW == 0 && fetch_valid(x, y)) ? 1 : 0);
      check($sformatf("font_en(%0d,%0d)", x, y), int'(font_mem_en),
            (x % CW == 1 && fetch_valid(x, y)) ? 1 : 0);
      x++;
      if (x == HT) begin
        x = 0;
        y = (y + 1) % VT;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ascii"}, int'(ascii_address), 0);
    check({tag, "_disp_en"}, int'(disp_mem_en), 0);
    check({tag, "_font_addr"}, int'(font_address), 0);
    check({tag, "_font_en"}, int'(font_mem_en), 0);
    check({tag, "_color"}, int'(pix_color), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_frames = 0;
  endtask

  logic [3:0] exp_seq[8];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    m_frames  = 0;
    reset     = 1'b1;
    pix_x     = '0;
    pix_y     = '0;
    cursor_en = 1'b0;
    cursor_x  = '0;
    cursor_y  = '0;

    for (int i = 0; i < 4096; i++) begin
      mem_char[i] = 8'($urandom_range(0, 255));
      mem_attr[i] = 8'($urandom_range(0, 255));
      mem_font[i] = 8'($urandom_range(0, 255));
    end
    mem_char[171]   = 8'h41;
    mem_char[5]     = 8'h80;
    mem_attr[5]     = 8'h1E;
    mem_font[12'h800] = 8'hA5;
    mem_char[163]   = 8'h22;
    mem_attr[163]   = 8'h5A;
    mem_font[12'h22D] = 8'hFF;
    mem_font[12'h22E] = 8'hF0;
    mem_font[12'h22F] = 8'h0F;
    mem_char[517]   = 8'h10;
    mem_attr[517]   = 8'h3C;
    mem_font[12'h104] = 8'hFF;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    m_frames = 0;

    // fetch-address table: {pix_x at p=0, pix_y, enable, ascii_address, glyph row}
    vecs[0] = '{x: 80,  y: 35,  en: 1'b1, addr: 171,  frow: 3};
    vecs[1] = '{x: 792, y: 15,  en: 1'b1, addr: 80,   frow: 0};
    vecs[2] = '{x: 632, y: 10,  en: 1'b0, addr: 0,    frow: 0};
    vecs[3] = '{x: 0,   y: 0,   en: 1'b1, addr: 1,    frow: 0};
    vecs[4] = '{x: 624, y: 479, en: 1'b1, addr: 2399, frow: 15};
    vecs[5] = '{x: 792, y: 479, en: 1'b0, addr: 0,    frow: 0};
    vecs[6] = '{x: 792, y: 524, en: 1'b1, addr: 0,    frow: 0};
    vecs[7] = '{x: 400, y: 300, en: 1'b1, addr: 1491, frow: 12};
    vecs[8] = '{x: 0,   y: 480, en: 1'b0, addr: 0,    frow: 0};
    vecs[9] = '{x: 784, y: 100, en: 1'b0, addr: 0,    frow: 0};
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_disp_en", i), int'(disp_mem_en), int'(vecs[i].en));
      if (vecs[i].en) check($sformatf("vec%0d_ascii", i), int'(ascii_address), vecs[i].addr);
      step(vecs[i].x + 1, vecs[i].y);
      check($sformatf("vec%0d_font_en", i), int'(font_mem_en), int'(vecs[i].en));
      check($sformatf("vec%0d_disp_off", i), int'(disp_mem_en), 0);
      if (vecs[i].en)
        check($sformatf("vec%0d_font_addr", i), int'(font_address),
              int'(mem_char[vecs[i].addr]) * CH + vecs[i].frow);
    end

    // glyph 0xA5 with attr 0x1E in cell (5,0)
    exp_seq = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE};
    for (int x = 32; x < 48; x++) begin
      step(x, 0);
      if (x >= 40) check($sformatf("glyph_a5_px%0d", x - 40), int'(pix_color), int'(exp_seq[x - 40]));
    end

    // right/bottom blanking and raster wrap corners
    scan(624, 200, 32, 8);
    scan(784, 479, 48, 8);
    scan(784, 524, 48, 8);
    scan(776, 15, 48, 8);
    scan(0, 100, 64, 8);

    // randomized raster segments
    for (int s = 0; s < 30; s++) begin
      cursor_en = 1'($urandom_range(0, 1));
      cursor_x  = 8'($urandom_range(0, COLS - 1));
      cursor_y  = 8'($urandom_range(0, ROWS - 1));
      scan($urandom_range(0, HT / CW - 1) * CW, $urandom_range(0, VT - 1), 48, 8);
    end

    // cursor at (3,2): blink edges at frame 16 and 32
    pulse_reset();
    cursor_en = 1'b1;
    cursor_x  = 8'd3;
    cursor_y  = 8'd2;
    for (int r = 45; r < 48; r++) scan(8, r, 40, 8);
    repeat (15) step(0, 0);
    scan(8, 46, 40, 8);
    step(0, 0);
    for (int r = 45; r < 48; r++) scan(8, r, 40, 8);
    scan(16, 46, 9, 9);
`ifdef TXT_CURSOR_EN
    check("cursor_px24", int'(pix_color), 5);
`else
    check("cursor_px24", int'(pix_color), 4'hA);
`endif
    repeat (16) step(0, 0);
    scan(8, 46, 40, 8);
    cursor_en = 1'b0;

    // asynchronous reset mid-line
    scan(280, 100, 21, 8);
    check("pre_reset_px300", int'(pix_color), 4'hC);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    m_frames = 0;
    step(301, 100);
    step(302, 100);
    check("reset_hold_color", int'(pix_color), 0);
    reset = 1'b0;
    step(303, 100);
    check("post_reset_px303", int'(pix_color), 0);
    scan(304, 100, 40, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
